// File: rtl/ext_mem_pkg.sv
// Shared types for the external memory model: per-channel FSM states and
// the width of the access-latency counter.
package ext_mem_pkg;

  localparam int CNT_BITS = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BUSY_RD = 3'd1,
    ST_BUSY_WR = 3'd2,
    ST_DONE_RD = 3'd3,
    ST_DONE_WR = 3'd4
  } ch_state_e;

endpackage

// File: rtl/ext_mem_channel.sv
// One request channel: FSM, latency counter and latched request. The storage
// lives in the parent; this block exposes a write-commit strobe and a read port.
module ext_mem_channel
  import ext_mem_pkg::*;
#(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int LATENCY      = 2,
  parameter int WRITE_ENABLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_read_valid,
  input  logic [ADDR_BITS-1:0] i_read_address,
  input  logic                 i_write_valid,
  input  logic [ADDR_BITS-1:0] i_write_address,
  input  logic [DATA_BITS-1:0] i_write_data,
  input  logic [DATA_BITS-1:0] i_mem_word,
  output logic [ADDR_BITS-1:0] o_addr,
  output logic [DATA_BITS-1:0] o_wr_data,
  output logic                 o_wr_commit,
  output logic                 o_read_ready,
  output logic [DATA_BITS-1:0] o_read_data,
  output logic                 o_write_ready
);

  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(LATENCY - 1);
  localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};

  ch_state_e            r_state;
  logic [CNT_BITS-1:0]  r_cnt;
  logic [ADDR_BITS-1:0] r_addr;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_read_ready;
  logic [DATA_BITS-1:0] r_read_data;
  logic                 r_write_ready;
  logic                 w_wr_req;

  assign w_wr_req      = (WRITE_ENABLE != 0) && i_write_valid;
  assign o_addr        = r_addr;
  assign o_wr_data     = r_data;
  // A write landing on a reset edge is dropped, never committed.
  assign o_wr_commit   = (r_state == ST_BUSY_WR) && (r_cnt == CNT_ZERO) && !reset;
  assign o_read_ready  = r_read_ready;
  assign o_read_data   = r_read_data;
  assign o_write_ready = (WRITE_ENABLE != 0) ? r_write_ready : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= CNT_ZERO;
      r_read_ready  <= 1'b0;
      r_read_data   <= {DATA_BITS{1'b0}};
      r_write_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_wr_req) begin
            r_state <= ST_BUSY_WR;
            r_cnt   <= CNT_LOAD;
            r_addr  <= i_write_address;
            r_data  <= i_write_data;
          end else if (i_read_valid) begin
            r_state <= ST_BUSY_RD;
            r_cnt   <= CNT_LOAD;
            r_addr  <= i_read_address;
          end
        end
        ST_BUSY_RD: begin
          if (r_cnt == CNT_ZERO) begin
            r_state      <= ST_DONE_RD;
            r_read_data  <= i_mem_word;
            r_read_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_BUSY_WR: begin
          if (r_cnt == CNT_ZERO) begin
            r_state       <= ST_DONE_WR;
            r_write_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_DONE_RD: begin
          if (!i_read_valid) begin
            r_read_ready <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        ST_DONE_WR: begin
          if (!i_write_valid) begin
            r_write_ready <= 1'b0;
            r_state       <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ext_mem.sv
// Multi-channel external memory model over one shared array. Define
// EXT_MEM_LOAD_PORT_EN to add the load_valid/load_address/load_data preload port.
module ext_mem
  import ext_mem_pkg::*;
#(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int CHANNELS     = 4,
  parameter int LATENCY      = 2,
  parameter int WRITE_ENABLE = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [CHANNELS-1:0]                 read_valid,
  input  logic [CHANNELS-1:0][ADDR_BITS-1:0]  read_address,
  output logic [CHANNELS-1:0]                 read_ready,
  output logic [CHANNELS-1:0][DATA_BITS-1:0]  read_data,
  input  logic [CHANNELS-1:0]                 write_valid,
  input  logic [CHANNELS-1:0][ADDR_BITS-1:0]  write_address,
  input  logic [CHANNELS-1:0][DATA_BITS-1:0]  write_data,
  output logic [CHANNELS-1:0]                 write_ready
`ifdef EXT_MEM_LOAD_PORT_EN
  ,
  input  logic                                load_valid,
  input  logic [ADDR_BITS-1:0]                load_address,
  input  logic [DATA_BITS-1:0]                load_data
`endif
);

  logic [DATA_BITS-1:0]               r_mem [2**ADDR_BITS];
  logic [CHANNELS-1:0][ADDR_BITS-1:0] w_addr;
  logic [CHANNELS-1:0][DATA_BITS-1:0] w_wr_data;
  logic [CHANNELS-1:0][DATA_BITS-1:0] w_mem_word;
  logic [CHANNELS-1:0]                w_commit;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign w_mem_word[g] = r_mem[w_addr[g]];

    ext_mem_channel #(
      .ADDR_BITS   (ADDR_BITS),
      .DATA_BITS   (DATA_BITS),
      .LATENCY     (LATENCY),
      .WRITE_ENABLE(WRITE_ENABLE)
    ) u_ch (
      .clk            (clk),
      .reset          (reset),
      .i_read_valid   (read_valid[g]),
      .i_read_address (read_address[g]),
      .i_write_valid  (write_valid[g]),
      .i_write_address(write_address[g]),
      .i_write_data   (write_data[g]),
      .i_mem_word     (w_mem_word[g]),
      .o_addr         (w_addr[g]),
      .o_wr_data      (w_wr_data[g]),
      .o_wr_commit    (w_commit[g]),
      .o_read_ready   (read_ready[g]),
      .o_read_data    (read_data[g]),
      .o_write_ready  (write_ready[g])
    );
  end

  // Later assignments win: ascending channel order gives the highest index
  // priority, and the preload port overrides every channel write.
  always_ff @(posedge clk) begin
    if (WRITE_ENABLE != 0) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_commit[c]) begin
          r_mem[w_addr[c]] <= w_wr_data[c];
        end
      end
    end
`ifdef EXT_MEM_LOAD_PORT_EN
    if (load_valid) begin
      r_mem[load_address] <= load_data;
    end
`endif
  end

endmodule
